stage_ex_muldiv: RTL

Iterative multiply/divide unit beside the `ex` stage, producing new `hi`/`lo` values for MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB and MSUBU. It accepts one operation at a time and raises a stall request while the operation is in flight. When the result is ready it drives `hi`/`lo` write enables in the same format the `ex` stage already forwards toward `mem`/`wb`. Operand width is a parameter; the CPU instantiates it with 32.

---
 rtl/stage_ex_muldiv_pkg.sv | 47 ++++
 rtl/stage_ex_muldiv_if.sv | 33 +++
 rtl/stage_ex_muldiv_divider.sv | 49 ++++
 rtl/stage_ex_muldiv.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_ex_muldiv_pkg.sv
// Shared operator codes, enable levels and state encodings for the iterative
// multiply/divide unit beside the ex stage.
package stage_ex_muldiv_pkg;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [7:0] OPERATOR_MULT  = 8'h18;
  localparam logic [7:0] OPERATOR_MULTU = 8'h19;
  localparam logic [7:0] OPERATOR_DIV   = 8'h1a;
  localparam logic [7:0] OPERATOR_DIVU  = 8'h1b;
  localparam logic [7:0] OPERATOR_MADD  = 8'h20;
  localparam logic [7:0] OPERATOR_MADDU = 8'h21;
  localparam logic [7:0] OPERATOR_MSUB  = 8'h22;
  localparam logic [7:0] OPERATOR_MSUBU = 8'h23;

  typedef enum logic [2:0] {
    MULDIV_STATE_IDLE = 3'd0,
    MULDIV_STATE_MUL  = 3'd1,
    MULDIV_STATE_DIV  = 3'd2,
    MULDIV_STATE_FIX  = 3'd3,
    MULDIV_STATE_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic is_madd_op(input logic [7:0] op);
    return (op == OPERATOR_MADD) || (op == OPERATOR_MADDU);
  endfunction

  function automatic logic is_msub_op(input logic [7:0] op);
    return (op == OPERATOR_MSUB) || (op == OPERATOR_MSUBU);
  endfunction

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == OPERATOR_MULT) || (op == OPERATOR_MULTU) || is_madd_op(op) || is_msub_op(op);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OPERATOR_DIV) || (op == OPERATOR_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == OPERATOR_MULT) || (op == OPERATOR_DIV) ||
           (op == OPERATOR_MADD) || (op == OPERATOR_MSUB);
  endfunction

endpackage

// File: rtl/stage_ex_muldiv_if.sv
// Request/result bundle between the ex stage (master) and the mul/div unit (slave).
interface stage_ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [7:0]       operator;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] lo_i;
  logic             cancel;
  logic             stall_request;
  logic             busy;
  logic             done;
  logic             register_hi_write_enable;
  logic             register_lo_write_enable;
  logic [WIDTH-1:0] register_hi_write_data;
  logic [WIDTH-1:0] register_lo_write_data;

  modport master (
    output start, operator, operand_a, operand_b, hi_i, lo_i, cancel,
    input  stall_request, busy, done,
           register_hi_write_enable, register_lo_write_enable,
           register_hi_write_data, register_lo_write_data
  );

  modport slave (
    input  start, operator, operand_a, operand_b, hi_i, lo_i, cancel,
    output stall_request, busy, done,
           register_hi_write_enable, register_lo_write_enable,
           register_hi_write_data, register_lo_write_data
  );
endinterface

// File: rtl/stage_ex_muldiv_divider.sv
// Unsigned restoring divider: one quotient bit per step, dividend shifted out of
// the quotient register as quotient bits shift in.
module restoring_divider
  import stage_ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   difference;
  logic             fits;

  // The partial remainder stays below the divisor, so the top bit of the trial
  // subtraction is a clean borrow flag.
  assign shifted    = {remainder_q, quotient_q[WIDTH-1]};
  assign difference = shifted - {1'b0, divisor_q};
  assign fits       = ~difference[WIDTH];

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      divisor_q   <= '0;
    end else if (load) begin
      quotient_q  <= dividend;
      remainder_q <= '0;
      divisor_q   <= divisor;
    end else if (step) begin
      quotient_q  <= {quotient_q[WIDTH-2:0], fits};
      remainder_q <= fits ? difference[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: rtl/stage_ex_muldiv.sv
// Iterative multiply/divide unit beside ex: computes new hi/lo for MULT*, DIV*,
// MADD* and MSUB* using magnitude arithmetic with a one-cycle sign fix-up.
module stage_ex_muldiv
  import stage_ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  stage_ex_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  muldiv_state_e      state;
  muldiv_state_e      state_next;
  logic [CW-1:0]      count;
  logic [7:0]         op_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_result_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic [WIDTH-1:0]   result_lo_q;

  logic               op_is_mul;
  logic               op_is_div;
  logic               op_is_signed;
  logic               start_valid;
  logic               accept;
  logic               divide_by_zero;
  logic               count_last;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] hilo_q;
  logic [2*WIDTH-1:0] product_fixed;
  logic [2*WIDTH-1:0] mul_final;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic [WIDTH-1:0]   quotient_fixed;
  logic [WIDTH-1:0]   remainder_fixed;
  logic               div_load;
  logic               div_step;

  assign op_is_mul      = is_mul_op(bus.operator);
  assign op_is_div      = is_div_op(bus.operator);
  assign op_is_signed   = is_signed_op(bus.operator);
  assign start_valid    = bus.start && (op_is_mul || op_is_div);
  assign accept         = (state == MULDIV_STATE_IDLE) && start_valid && !bus.cancel;
  assign divide_by_zero = op_is_div && (bus.operand_b == '0);
  assign count_last     = (count == CW'(WIDTH - 1));

  assign a_neg = op_is_signed && bus.operand_a[WIDTH-1];
  assign b_neg = op_is_signed && bus.operand_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag = b_neg ? -bus.operand_b : bus.operand_b;

  // Shift-add: the low half of the accumulator starts as the multiplier and is
  // consumed LSB first while the partial product grows into the high half.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign hilo_q          = {hi_q, lo_q};
  assign product_fixed   = neg_result_q ? -acc_q : acc_q;
  assign quotient_fixed  = neg_result_q ? -quotient : quotient;
  assign remainder_fixed = neg_rem_q ? -remainder : remainder;

  always_comb begin
    mul_final = product_fixed;
    if (is_madd_op(op_q)) begin
      mul_final = hilo_q + product_fixed;
    end else if (is_msub_op(op_q)) begin
      mul_final = hilo_q - product_fixed;
    end
  end

  assign div_load = accept && op_is_div && !divide_by_zero;
  assign div_step = (state == MULDIV_STATE_DIV);

  restoring_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clock    (clock),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (quotient),
    .remainder(remainder)
  );

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state <= MULDIV_STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cancel outranks everything, including the DONE strobe of the same cycle.
  always_comb begin
    state_next                   = state;
    bus.stall_request            = 1'b0;
    bus.busy                     = 1'b0;
    bus.done                     = 1'b0;
    bus.register_hi_write_enable = WRITE_DISABLE;
    bus.register_lo_write_enable = WRITE_DISABLE;
    bus.register_hi_write_data   = '0;
    bus.register_lo_write_data   = '0;

    if (bus.cancel) begin
      state_next = MULDIV_STATE_IDLE;
    end else begin
      case (state)
        MULDIV_STATE_IDLE: begin
          if (start_valid) begin
            if (op_is_mul) begin
              state_next = MULDIV_STATE_MUL;
            end else if (divide_by_zero) begin
              state_next = MULDIV_STATE_DONE;
            end else begin
              state_next = MULDIV_STATE_DIV;
            end
          end
        end
        MULDIV_STATE_MUL,
        MULDIV_STATE_DIV: begin
          if (count_last) begin
            state_next = MULDIV_STATE_FIX;
          end
        end
        MULDIV_STATE_FIX:  state_next = MULDIV_STATE_DONE;
        MULDIV_STATE_DONE: state_next = MULDIV_STATE_IDLE;
        default:           state_next = MULDIV_STATE_IDLE;
      endcase
    end

    if (reset != RESET_ENABLE) begin
      bus.busy          = (state != MULDIV_STATE_IDLE);
      bus.stall_request = ((state == MULDIV_STATE_IDLE) && start_valid) ||
                          (state == MULDIV_STATE_MUL) ||
                          (state == MULDIV_STATE_DIV) ||
                          (state == MULDIV_STATE_FIX);
      if ((state == MULDIV_STATE_DONE) && !bus.cancel) begin
        bus.done                     = 1'b1;
        bus.register_hi_write_enable = WRITE_ENABLE;
        bus.register_lo_write_enable = WRITE_ENABLE;
        bus.register_hi_write_data   = result_hi_q;
        bus.register_lo_write_data   = result_lo_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      count        <= '0;
      op_q         <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mcand_q      <= '0;
      acc_q        <= '0;
      neg_result_q <= 1'b0;
      neg_rem_q    <= 1'b0;
      result_hi_q  <= '0;
      result_lo_q  <= '0;
    end else begin
      case (state)
        MULDIV_STATE_IDLE: begin
          if (accept) begin
            count        <= '0;
            op_q         <= bus.operator;
            hi_q         <= bus.hi_i;
            lo_q         <= bus.lo_i;
            mcand_q      <= a_mag;
            acc_q        <= {{WIDTH{1'b0}}, b_mag};
            neg_result_q <= a_neg ^ b_neg;
            neg_rem_q    <= a_neg;
            if (divide_by_zero) begin
              result_hi_q <= bus.operand_a;
              result_lo_q <= '1;
            end
          end
        end
        MULDIV_STATE_MUL: begin
          acc_q <= acc_next;
          count <= count + 1'b1;
        end
        MULDIV_STATE_DIV: begin
          count <= count + 1'b1;
        end
        MULDIV_STATE_FIX: begin
          if (is_div_op(op_q)) begin
            result_hi_q <= remainder_fixed;
            result_lo_q <= quotient_fixed;
          end else begin
            {result_hi_q, result_lo_q} <= mul_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
